boot_loader_seq: RTL

- UART-driven boot loader sequencer. While the system is in boot mode, it parses a byte protocol from the UART receiver.
- It writes payload data into external SRAM through a single-master request/ack port, acknowledging each command on the UART transmitter.
- On the go command it pulses bootmode_end_cmd and releases the SRAM to the CPU.

---
 rtl/boot_loader_seq.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/boot_loader_seq.sv
// UART-driven boot loader: parses 'L' (load) and 'G' (go) commands and writes payload bytes to SRAM.
// Define BOOT_CHECKSUM_EN to append an 8-bit data checksum byte after each 'K' acknowledge.
module boot_loader_seq #(
   parameter int ADDR_W     = 19,
   parameter int RX_TIMEOUT = 1000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_avail,
   output logic              rx_avail_clear,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_active,
   output logic              mem_req,
   input  logic              mem_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_data_write,
   output logic              mem_uds,
   output logic              mem_lds,
   output logic              mem_rw,
   output logic              bootmode,
   output logic              bootmode_end_cmd
);

   localparam int PW = ADDR_W + 1;
   localparam int TW = (RX_TIMEOUT > 0) ? $clog2(RX_TIMEOUT + 1) : 1;

   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_GO   = 8'h47;
   localparam logic [7:0] RSP_OK   = 8'h4B;
   localparam logic [7:0] RSP_ERR  = 8'h3F;
   localparam logic [7:0] RSP_TMO  = 8'h21;

   typedef enum logic [3:0] {
      IDLE, A2, A1, A0, L1, L0, DATA_HI, DATA_LO, WRITE, RESP, DONE
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [15:0]     rem_q, rem_d;
   logic [7:0]      hi_q, hi_d;
   logic [7:0]      lo_q, lo_d;
   logic            uds_q, uds_d;
   logic            lds_q, lds_d;
   logic            armed_q, armed_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [7:0]      tx_byte_q, tx_byte_d;
   logic            end_q, end_d;
   logic            boot_q, boot_d;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]      csum_q, csum_d;
   logic            csum_pend_q, csum_pend_d;
`endif

   logic            rx_wait;
   logic            in_cmd;
   logic            tmo_hit;
   logic            consume;
   logic [15:0]     len_new;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
      state_d     = state_q;
      ptr_d       = ptr_q;
      rem_d       = rem_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      uds_d       = uds_q;
      lds_d       = lds_q;
      tx_byte_d   = tx_byte_q;
      end_d       = 1'b0;
      boot_d      = boot_q;
      tx_start    = 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_d      = csum_q;
      csum_pend_d = csum_pend_q;
`endif

      in_cmd  = state_q inside {A2, A1, A0, L1, L0, DATA_HI, DATA_LO};
      rx_wait = in_cmd || (state_q == IDLE);
      tmo_hit = (RX_TIMEOUT != 0) && in_cmd && (tmo_q == TW'(RX_TIMEOUT));
      // Mealy consume: the byte is sampled in the same cycle the clear pulse goes out.
      consume = rx_wait && rx_avail && armed_q && !tmo_hit;
      len_new = {rem_q[7:0], rx_data};

      if (consume)       armed_d = 1'b0;
      else if (!rx_avail) armed_d = 1'b1;
      else               armed_d = armed_q;

      if (consume || !in_cmd || RX_TIMEOUT == 0) tmo_d = '0;
      else                                        tmo_d = tmo_q + TW'(1);

      if (tmo_hit) begin
         tx_byte_d = RSP_TMO;
         state_d   = RESP;
      end else begin
         case (state_q)
            IDLE: if (consume) begin
               if (rx_data == CMD_LOAD) begin
                  ptr_d   = '0;
                  state_d = A2;
`ifdef BOOT_CHECKSUM_EN
                  csum_d  = 8'h00;
`endif
               end else if (rx_data == CMD_GO) begin
                  end_d   = 1'b1;
                  boot_d  = 1'b0;
                  state_d = DONE;
               end else begin
                  tx_byte_d = RSP_ERR;
                  state_d   = RESP;
               end
            end
            A2, A1, A0: if (consume) begin
               ptr_d   = PW'({ptr_q, rx_data});
               state_d = (state_q == A2) ? A1 : (state_q == A1) ? A0 : L1;
            end
            L1: if (consume) begin
               rem_d   = len_new;
               state_d = L0;
            end
            L0: if (consume) begin
               rem_d = len_new;
               if (len_new == 16'd0) begin
                  tx_byte_d = RSP_OK;
                  state_d   = RESP;
`ifdef BOOT_CHECKSUM_EN
                  csum_pend_d = 1'b1;
`endif
               end else if (ptr_q[0]) begin
                  hi_d    = 8'h00;
                  uds_d   = 1'b0;
                  state_d = DATA_LO;
               end else begin
                  state_d = DATA_HI;
               end
            end
            DATA_HI: if (consume) begin
               hi_d  = rx_data;
               uds_d = 1'b1;
               rem_d = rem_q - 16'd1;
`ifdef BOOT_CHECKSUM_EN
               csum_d = csum_q + rx_data;
`endif
               if (rem_q == 16'd1) begin
                  lo_d    = 8'h00;
                  lds_d   = 1'b0;
                  state_d = WRITE;
               end else begin
                  state_d = DATA_LO;
               end
            end
            DATA_LO: if (consume) begin
               lo_d    = rx_data;
               lds_d   = 1'b1;
               rem_d   = rem_q - 16'd1;
               state_d = WRITE;
`ifdef BOOT_CHECKSUM_EN
               csum_d  = csum_q + rx_data;
`endif
            end
            // After any completed write with bytes left the pointer is even again.
            WRITE: if (mem_ack) begin
               ptr_d = ptr_q + PW'(uds_q) + PW'(lds_q);
               if (rem_q == 16'd0) begin
                  tx_byte_d = RSP_OK;
                  state_d   = RESP;
`ifdef BOOT_CHECKSUM_EN
                  csum_pend_d = 1'b1;
`endif
               end else begin
                  state_d = DATA_HI;
               end
            end
            RESP: if (!tx_active) begin
               tx_start = 1'b1;
`ifdef BOOT_CHECKSUM_EN
               if (csum_pend_q) begin
                  tx_byte_d   = csum_q;
                  csum_pend_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
`else
               state_d = IDLE;
`endif
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
         endcase
      end

      rx_avail_clear   = consume;
      tx_data          = tx_byte_q;
      mem_req          = (state_q == WRITE);
      mem_addr         = mem_req ? ptr_q[ADDR_W:1] : '0;
      mem_data_write   = mem_req ? {hi_q, lo_q} : 16'h0000;
      mem_uds          = mem_req & uds_q;
      mem_lds          = mem_req & lds_q;
      mem_rw           = ~mem_req;
      bootmode         = boot_q;
      bootmode_end_cmd = end_q;
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         rem_q       <= 16'h0000;
         hi_q        <= 8'h00;
         lo_q        <= 8'h00;
         uds_q       <= 1'b0;
         lds_q       <= 1'b0;
         armed_q     <= 1'b0;
         tmo_q       <= '0;
         tx_byte_q   <= 8'h00;
         end_q       <= 1'b0;
         boot_q      <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
         csum_q      <= 8'h00;
         csum_pend_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         rem_q       <= rem_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         uds_q       <= uds_d;
         lds_q       <= lds_d;
         armed_q     <= armed_d;
         tmo_q       <= tmo_d;
         tx_byte_q   <= tx_byte_d;
         end_q       <= end_d;
         boot_q      <= boot_d;
`ifdef BOOT_CHECKSUM_EN
         csum_q      <= csum_d;
         csum_pend_q <= csum_pend_d;
`endif
      end
   end

endmodule
